// File: rtl/serial_frame_receiver_if.sv
// rtl/serial_frame_receiver_if.sv - received-word valid/ready output bus
interface serial_frame_receiver_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - strobe-sampled start/data/parity/stop frame receiver
module serial_frame_receiver #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sdin,
  input  logic                   bit_en,
  serial_frame_receiver_if.master out_if,
  output logic                   frame_err,
  output logic                   parity_err,
  output logic                   overrun,
  output logic                   busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
  logic             overrun_q, overrun_d;
  logic             par_ok;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q & ~out_if.dout_ready;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;
    par_ok       = (PARITY_EN == 1'b0) || ((^shreg_q) == par_q);

    if (bit_en) begin
      case (state_q)
        S_IDLE: begin
          if (!sdin) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        S_DATA: begin
          shreg_d = {sdin, shreg_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = (PARITY_EN != 1'b0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          par_d   = sdin;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d      = S_IDLE;
          frame_err_d  = ~sdin;
          parity_err_d = ~par_ok;
          // A consumer draining the register on this same edge frees room for the new word
          if (sdin && par_ok) begin
            if (!dout_valid_q || out_if.dout_ready) begin
              dout_d       = shreg_q;
              dout_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_if.dout       = dout_q;
  assign out_if.dout_valid = dout_valid_q;
  assign frame_err         = frame_err_q;
  assign parity_err        = parity_err_q;
  assign overrun           = overrun_q;
  assign busy              = (state_q != S_IDLE);
endmodule
